// File: rtl/hold_slot_ctrl.sv
// Hold-slot manager: owns the held piece, swaps it with the falling piece on a hold
// request and offers the replacement to spawn logic. Optional preview blink: HOLD_BLINK_EN.

`ifndef BITS_PER_BLOCK
`define BITS_PER_BLOCK 3
`endif
`ifndef EMPTY_BLOCK
`define EMPTY_BLOCK 3'd0
`endif

module hold_slot_ctrl #(
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         hold_req,
    input  logic                         piece_locked,
    input  logic [`BITS_PER_BLOCK-1:0]   cur_piece,
    output logic                         next_req,
    input  logic                         next_valid,
    input  logic [`BITS_PER_BLOCK-1:0]   next_piece,
    output logic                         spawn_valid,
    input  logic                         spawn_ready,
    output logic [`BITS_PER_BLOCK-1:0]   spawn_piece,
    output logic [`BITS_PER_BLOCK-1:0]   hold_piece,
    output logic                         hold_view,
    output logic                         hold_rej
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        OFFER = 2'd2
    } state_t;

    if (BLINK_CYCLES < 1) begin : g_bad_blink_cycles
        $error("BLINK_CYCLES must be at least 1");
    end

    state_t                       state, state_d;
    logic [`BITS_PER_BLOCK-1:0]   hold_piece_d, spawn_piece_d;
    logic                         hold_used, hold_used_d;
    logic                         hold_rej_d;
    logic                         accept;
    logic                         slot_full;

    assign slot_full = (hold_piece != `EMPTY_BLOCK);

    // Handshake outputs decode straight from the state register, so they are glitch-free
    // and already carry the one-cycle latency after the deciding edge.
    assign next_req    = (state == FETCH);
    assign spawn_valid = (state == OFFER);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d       = state;
        hold_piece_d  = hold_piece;
        spawn_piece_d = spawn_piece;
        hold_used_d   = hold_used;
        accept        = 1'b0;

        if (state == IDLE && hold_req && !hold_used && !piece_locked
            && cur_piece != `EMPTY_BLOCK) begin
            accept = 1'b1;
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    hold_piece_d = cur_piece;
                    if (!slot_full) begin
                        state_d = FETCH;
                    end else begin
                        spawn_piece_d = hold_piece;
                        state_d       = OFFER;
                    end
                end
            end
            FETCH: begin
                if (next_valid) begin
                    spawn_piece_d = next_piece;
                    state_d       = OFFER;
                end
            end
            OFFER: begin
                if (spawn_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A landing piece re-arms hold and beats a same-cycle request.
        if (piece_locked) begin
            hold_used_d = 1'b0;
        end else if (accept) begin
            hold_used_d = 1'b1;
        end

        hold_rej_d = hold_req && !accept;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hold_piece  <= `EMPTY_BLOCK;
            spawn_piece <= `EMPTY_BLOCK;
            hold_used   <= 1'b0;
            hold_rej    <= 1'b0;
        end else begin
            state       <= state_d;
            hold_piece  <= hold_piece_d;
            spawn_piece <= spawn_piece_d;
            hold_used   <= hold_used_d;
            hold_rej    <= hold_rej_d;
        end
    end

`ifdef HOLD_BLINK_EN
    localparam int CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic [CNT_W-1:0] blink_cnt;
    logic             blinking;
    logic             hold_used_rise;

    assign blinking       = hold_used && slot_full;
    assign hold_used_rise = hold_used_d && !hold_used;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            hold_view <= 1'b0;
        end else if (hold_used_rise) begin
            blink_cnt <= '0;
            hold_view <= slot_full;
        end else if (!blinking) begin
            blink_cnt <= '0;
            hold_view <= slot_full;
        end else if (blink_cnt == CNT_W'(BLINK_CYCLES - 1)) begin
            blink_cnt <= '0;
            hold_view <= !hold_view;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_view <= 1'b0;
        end else begin
            hold_view <= slot_full;
        end
    end
`endif

endmodule

// File: tb/tb_hold_slot_ctrl.sv
// Directed self-checking bench for hold_slot_ctrl: fetch, swap, double hold, stall,
// lock/hold collision and reset mid-fetch.

`ifndef BITS_PER_BLOCK
`define BITS_PER_BLOCK 3
`endif
`ifndef EMPTY_BLOCK
`define EMPTY_BLOCK 3'd0
`endif
`ifndef I_BLOCK
`define I_BLOCK 3'd1
`endif
`ifndef O_BLOCK
`define O_BLOCK 3'd2
`endif
`ifndef T_BLOCK
`define T_BLOCK 3'd3
`endif
`ifndef S_BLOCK
`define S_BLOCK 3'd4
`endif
`ifndef Z_BLOCK
`define Z_BLOCK 3'd5
`endif

module tb_hold_slot_ctrl;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       hold_req;
    logic                       piece_locked;
    logic [`BITS_PER_BLOCK-1:0] cur_piece;
    logic                       next_req;
    logic                       next_valid;
    logic [`BITS_PER_BLOCK-1:0] next_piece;
    logic                       spawn_valid;
    logic                       spawn_ready;
    logic [`BITS_PER_BLOCK-1:0] spawn_piece;
    logic [`BITS_PER_BLOCK-1:0] hold_piece;
    logic                       hold_view;
    logic                       hold_rej;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hold_slot_ctrl #(.BLINK_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .hold_req     (hold_req),
        .piece_locked (piece_locked),
        .cur_piece    (cur_piece),
        .next_req     (next_req),
        .next_valid   (next_valid),
        .next_piece   (next_piece),
        .spawn_valid  (spawn_valid),
        .spawn_ready  (spawn_ready),
        .spawn_piece  (spawn_piece),
        .hold_piece   (hold_piece),
        .hold_view    (hold_view),
        .hold_rej     (hold_rej)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one edge; outputs are sampled and inputs changed 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; hold_req = 1'b0; piece_locked = 1'b0; cur_piece = `EMPTY_BLOCK;
        next_valid = 1'b0; next_piece = `EMPTY_BLOCK; spawn_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_hold_piece",  32'(hold_piece),  32'(`EMPTY_BLOCK));
        check("rst_spawn_piece", 32'(spawn_piece), 32'(`EMPTY_BLOCK));
        check("rst_next_req",    32'(next_req),    32'd0);
        check("rst_spawn_valid", 32'(spawn_valid), 32'd0);
        check("rst_hold_rej",    32'(hold_rej),    32'd0);
        check("rst_hold_view",   32'(hold_view),   32'd0);

        // Fetch path: empty slot
        cur_piece = `T_BLOCK; hold_req = 1'b1;
        tick();
        hold_req = 1'b0;
        check("fetch_next_req",     32'(next_req),    32'd1);
        check("fetch_spawn_valid0", 32'(spawn_valid), 32'd0);
        check("fetch_hold_piece",   32'(hold_piece),  32'(`T_BLOCK));
        check("fetch_view_lag",     32'(hold_view),   32'd0);
        check("fetch_no_rej",       32'(hold_rej),    32'd0);
        tick();
        check("fetch_wait_req",     32'(next_req),    32'd1);
        check("fetch_view",         32'(hold_view),   32'd1);
        next_valid = 1'b1; next_piece = `I_BLOCK;
        tick();
        next_valid = 1'b0; next_piece = `EMPTY_BLOCK;
        check("fetch_spawn_valid",  32'(spawn_valid), 32'd1);
        check("fetch_spawn_piece",  32'(spawn_piece), 32'(`I_BLOCK));
        check("fetch_req_drop",     32'(next_req),    32'd0);
        check("fetch_hold_keep",    32'(hold_piece),  32'(`T_BLOCK));
        check("fetch_view_keep",    32'(hold_view),   32'd1);
        spawn_ready = 1'b1;
        tick();
        spawn_ready = 1'b0;
        check("fetch_xfer_done",    32'(spawn_valid), 32'd0);

        // Double hold: no lock since the last accepted hold
        cur_piece = `I_BLOCK; hold_req = 1'b1;
        tick();
        hold_req = 1'b0;
        check("dbl_rej",         32'(hold_rej),    32'd1);
        check("dbl_hold_piece",  32'(hold_piece),  32'(`T_BLOCK));
        check("dbl_spawn_valid", 32'(spawn_valid), 32'd0);
        check("dbl_next_req",    32'(next_req),    32'd0);
        tick();
        check("dbl_rej_pulse",   32'(hold_rej),    32'd0);

        // Swap path: occupied slot after a lock
        piece_locked = 1'b1;
        tick();
        piece_locked = 1'b0;
        cur_piece = `S_BLOCK; hold_req = 1'b1;
        tick();
        hold_req = 1'b0;
        check("swap_spawn_valid", 32'(spawn_valid), 32'd1);
        check("swap_spawn_piece", 32'(spawn_piece), 32'(`T_BLOCK));
        check("swap_hold_piece",  32'(hold_piece),  32'(`S_BLOCK));
        check("swap_next_req",    32'(next_req),    32'd0);

        // Stall in OFFER for 10 cycles; a hold_req mid-stall is rejected
        for (int i = 0; i < 10; i++) begin
            hold_req = (i == 4);
            tick();
            check("stall_valid",  32'(spawn_valid), 32'd1);
            check("stall_piece",  32'(spawn_piece), 32'(`T_BLOCK));
            check("stall_noreq",  32'(next_req),    32'd0);
            check("stall_rej",    32'(hold_rej),    32'(i == 4));
            check("stall_hold",   32'(hold_piece),  32'(`S_BLOCK));
        end
        hold_req = 1'b0;
        spawn_ready = 1'b1;
        tick();
        spawn_ready = 1'b0;
        check("stall_release",  32'(spawn_valid), 32'd0);
        check("stall_idle_req", 32'(next_req),    32'd0);

        // Collision: lock and hold in the same IDLE cycle
        cur_piece = `O_BLOCK; hold_req = 1'b1; piece_locked = 1'b1;
        tick();
        hold_req = 1'b0; piece_locked = 1'b0;
        check("coll_rej",         32'(hold_rej),      32'd1);
        check("coll_used",        32'(dut.hold_used), 32'd0);
        check("coll_spawn_valid", 32'(spawn_valid),   32'd0);
        check("coll_next_req",    32'(next_req),      32'd0);
        check("coll_hold_piece",  32'(hold_piece),    32'(`S_BLOCK));
        hold_req = 1'b1;
        tick();
        hold_req = 1'b0;
        check("coll_after_valid", 32'(spawn_valid), 32'd1);
        check("coll_after_piece", 32'(spawn_piece), 32'(`S_BLOCK));
        check("coll_after_hold",  32'(hold_piece),  32'(`O_BLOCK));
        spawn_ready = 1'b1;
        tick();
        spawn_ready = 1'b0;

        // Empty falling piece cannot be held
        piece_locked = 1'b1;
        tick();
        piece_locked = 1'b0;
        cur_piece = `EMPTY_BLOCK; hold_req = 1'b1;
        tick();
        hold_req = 1'b0;
        check("empty_cur_rej",  32'(hold_rej),   32'd1);
        check("empty_cur_hold", 32'(hold_piece), 32'(`O_BLOCK));

        // Reset mid-FETCH, with next_valid on the reset edge
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cur_piece = `Z_BLOCK; hold_req = 1'b1;
        tick();
        hold_req = 1'b0;
        check("rf_next_req",  32'(next_req),   32'd1);
        tick();
        check("rf_view",      32'(hold_view),  32'd1);
        rst = 1'b1; next_valid = 1'b1; next_piece = `I_BLOCK;
        tick();
        rst = 1'b0; next_valid = 1'b0;
        check("rf_next_req0",    32'(next_req),    32'd0);
        check("rf_hold_piece",   32'(hold_piece),  32'(`EMPTY_BLOCK));
        check("rf_hold_view",    32'(hold_view),   32'd0);
        check("rf_spawn_valid",  32'(spawn_valid), 32'd0);
        check("rf_spawn_piece",  32'(spawn_piece), 32'(`EMPTY_BLOCK));
        tick();
        check("rf_stays_idle",   32'(spawn_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hold_slot_ctrl.md
# hold_slot_ctrl

Hold-slot manager for the Tetris core: owns the held-piece register that drives the hold preview's `piece` input, swaps the falling piece with the held one on a player hold request, and hands the replacement piece to the spawn logic through a valid/ready handshake. It sits between the keyboard/game FSM, the random piece generator, and the hold-preview coordinate/renderer path. Only one hold is allowed per dropped piece.

## Interface
Parameters:
- BLINK_CYCLES, 12_500_000: half-period of the hold-preview blink, in clk cycles; used only with the blink macro.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- hold_req  input  1  single-cycle hold request from the key decoder.
- piece_locked  input  1  single-cycle pulse when the falling piece lands.
- cur_piece  input  `BITS_PER_BLOCK  type of the currently falling piece.
- next_req  output  1  request for a fresh piece from the generator.
- next_valid  input  1  generator has a piece on next_piece.
- next_piece  input  `BITS_PER_BLOCK  generator piece type.
- spawn_valid  output  1  spawn_piece is offered to the game FSM.
- spawn_ready  input  1  game FSM accepts spawn_piece.
- spawn_piece  output  `BITS_PER_BLOCK  piece that replaces the falling piece.
- hold_piece  output  `BITS_PER_BLOCK  held piece; feeds the preview `piece` input.
- hold_view  output  1  preview enable; feeds the preview `view` input.
- hold_rej  output  1  single-cycle pulse when a hold_req is ignored.

## Operation
- Reset values: hold_piece=`EMPTY_BLOCK, spawn_piece=`EMPTY_BLOCK, next_req=0, spawn_valid=0, hold_rej=0, hold_view=0, hold_used=0, state=IDLE.
- States: IDLE, FETCH, OFFER.
- IDLE, hold_req=1, hold_used=0, cur_piece!=`EMPTY_BLOCK, piece_locked=0: the request is accepted. Set hold_piece<=cur_piece and hold_used<=1.
  - If the old hold_piece was `EMPTY_BLOCK, go to FETCH.
  - Otherwise set spawn_piece<=old hold_piece and go to OFFER.
- IDLE, hold_req=1, otherwise: the request is rejected. Pulse hold_rej. No state change.
- hold_req in FETCH or OFFER: rejected, hold_rej pulses.
- FETCH: next_req=1. On a sampled next_valid=1, set spawn_piece<=next_piece, drop next_req, go to OFFER.
- OFFER: spawn_valid=1. spawn_piece stays stable until a sampled spawn_ready=1, then go to IDLE.
- piece_locked clears hold_used in any state.
- piece_locked and hold_req together in IDLE: the lock wins, hold_req is rejected, and hold_used ends at 0.
- hold_view = (hold_piece!=`EMPTY_BLOCK), registered.
- hold_piece changes only on an accepted hold or on rst.

## Timing
- Accepted hold, occupied slot: spawn_valid is high on the cycle after the hold_req edge (latency 1).
- Accepted hold, empty slot: next_req is high on the cycle after hold_req. spawn_valid rises 1 cycle after the edge that samples next_valid.
- Minimum hold-to-spawn transfer: 2 cycles for the swap path, 3 cycles for the fetch path.
- A transfer occurs on an edge with spawn_valid=1 and spawn_ready=1. spawn_valid is 0 the following cycle.
- hold_rej is registered and is high exactly 1 cycle after the offending hold_req.
- hold_view is registered and lags hold_piece by 1 cycle.
- rst asserted in any state, including mid-FETCH or mid-OFFER, returns all outputs to their reset values on that edge. No transfer completes on that edge.

## Configuration
- HOLD_BLINK_EN defined:
  - While hold_used=1 and the slot is non-empty, hold_view toggles every BLINK_CYCLES cycles, using an internal counter that is reset on rst and on every hold_used rise.
  - Once hold_used clears, hold_view returns to (hold_piece!=`EMPTY_BLOCK) on the next cycle.
- HOLD_BLINK_EN undefined: hold_view = (hold_piece!=`EMPTY_BLOCK), with no counter synthesized.

## Test plan
- Fetch path: after rst, cur_piece=`T_BLOCK, hold_req pulse.
  - Required: next_req=1 next cycle. Drive next_valid with next_piece=`I_BLOCK; spawn_valid=1 and spawn_piece=`I_BLOCK one cycle later. hold_piece=`T_BLOCK, hold_view=1.
- Swap path: hold_piece=`T_BLOCK, piece_locked pulse, then cur_piece=`S_BLOCK and hold_req.
  - Required: spawn_valid=1 after 1 cycle, spawn_piece=`T_BLOCK, hold_piece=`S_BLOCK, next_req never asserted.
- Double hold: two hold_req pulses with no piece_locked between them.
  - Required: the second produces hold_rej=1 for one cycle, and hold_piece is unchanged.
- Stall: hold spawn_ready=0 for 10 cycles in OFFER.
  - Required: spawn_valid and spawn_piece stay stable throughout. Raise spawn_ready; spawn_valid=0 the next cycle, state IDLE.
- Collision: hold_req and piece_locked in the same cycle in IDLE.
  - Required: hold_rej=1, hold_used=0, no spawn_valid.
- Reset mid-FETCH: assert rst while next_req=1.
  - Required: next edge gives next_req=0, hold_piece=`EMPTY_BLOCK, hold_view=0, spawn_valid=0.
